// File: rtl/fp_mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FP constants, FSM encoding
// and a small wrap-around increment helper used for the round-robin pointer.
// No ports; imported by fp_mul_arbiter and fp_mul_arbiter_rr.
package fp_mul_arbiter_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // (idx + 1) mod n without a divider
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_rr.sv
// Round-robin grant selection: picks the first eligible requester at or after ptr, wrapping.
// Ports: elig[N] eligible mask, ptr start position; gnt one-hot grant, gnt_idx binary grant.
// Purely combinational; gnt is all-zero when nothing is eligible.
module fp_mul_arbiter_rr #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && elig[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP multiplier core among N requesters: round-robin grant, 1-cycle start, wait for done,
// result posted to a per-requester valid/ready register; a watchdog posts QNAN+err if done never comes.
// Ports: req_* (valid/op1/op2 in, ready pulse out), rsp_* (valid/res/err out, ready in),
// mul_* (core start/operands out, result/done in), busy, err_timeout (sticky until rst).
module fp_mul_arbiter
    import fp_mul_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [FP_W*N-1:0]    req_op1,
    input  logic [FP_W*N-1:0]    req_op2,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    output logic [FP_W*N-1:0]    rsp_res,
    output logic [N-1:0]         rsp_err,
    input  logic [N-1:0]         rsp_ready,
    output logic                 mul_ready,
    output logic [FP_W-1:0]      mul_op1,
    output logic [FP_W-1:0]      mul_op2,
    input  logic [FP_W-1:0]      mul_res,
    input  logic                 mul_done,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic [PW-1:0]          g_q, g_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [FP_W-1:0]        op1_q, op1_d, op2_q, op2_d;
    logic [N-1:0]           vld_q, vld_d, err_q, err_d;
    logic [N-1:0][FP_W-1:0] res_q, res_d;
    logic                   tout_q, tout_d;

    logic [N-1:0][FP_W-1:0] op1_v, op2_v;
    logic [N-1:0]           elig, gnt;
    logic [PW-1:0]          gnt_idx;

    assign op1_v = req_op1;
    assign op2_v = req_op2;

    // A requester still holding an unconsumed result is never granted,
    // so a capture can never overwrite a pending response.
    assign elig    = req_valid & ~vld_q;
    assign cnt_inc = cnt_q + CW'(1);

    fp_mul_arbiter_rr #(
        .N  (N),
        .PW (PW)
    ) u_rr (
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        vld_d     = vld_q & ~rsp_ready;
        err_d     = err_q;
        res_d     = res_q;
        tout_d    = tout_q;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    g_d       = gnt_idx;
                    op1_d     = op1_v[gnt_idx];
                    op2_d     = op2_v[gnt_idx];
                    req_ready = gnt;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done has priority over a watchdog expiry in the same cycle
                if (mul_done || cnt_inc == CW'(TIMEOUT)) begin
                    vld_d[g_q] = 1'b1;
                    err_d[g_q] = ~mul_done;
                    res_d[g_q] = mul_done ? mul_res : FP_QNAN;
                    tout_d     = tout_q | ~mul_done;
                    ptr_d      = PW'(wrap_inc(int'(g_q), N));
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            res_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            res_q   <= res_d;
            tout_q  <= tout_d;
        end
    end

    assign mul_ready   = (state_q == ST_ISSUE);
    assign mul_op1     = op1_q;
    assign mul_op2     = op2_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = tout_q;
    assign rsp_valid   = vld_q;
    assign rsp_err     = err_q;
    assign rsp_res     = res_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter with a behavioural multiplier core model.
// Stimulus drives requests and grants; a monitor process scores responses from a queue.
module tb_fp_mul_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_op1;
    logic [32*N-1:0] req_op2;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [32*N-1:0] rsp_res;
    logic [N-1:0]    rsp_err;
    logic [N-1:0]    rsp_ready;
    logic            mul_ready;
    logic [31:0]     mul_op1;
    logic [31:0]     mul_op2;
    logic [31:0]     mul_res;
    logic            mul_done;
    logic            busy;
    logic            err_timeout;

    logic core_done;
    logic stray_done;
    assign mul_done = core_done | stray_done;

    fp_mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_res     (rsp_res),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready),
        .mul_ready   (mul_ready),
        .mul_op1     (mul_op1),
        .mul_op2     (mul_op2),
        .mul_res     (mul_res),
        .mul_done    (mul_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } sb_t;

    sb_t         sb_q[$];
    int          gorder[$];
    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    int          pulses = 0;
    int          model_ptr = 0;
    int          gcnt [N];
    int          ops_left [N];
    logic [31:0] exp_res [N];
    logic        dir_use [N];
    logic [31:0] dir_op1 [N];
    logic [31:0] dir_op2 [N];
    logic [31:0] dir_exp [N];
    bit          hang = 0;
    int          fixed_lat = 0;
    int          rdy_mode = 1;
    int          gap_mode = 0;
    int          skip_cnt = 0;
    bit          issue_pend = 0;
    logic [31:0] iss_op1, iss_op2;

    // IEEE single multiply, round-to-nearest-even, subnormals flushed to zero
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic        s, gb, st;
        int          ea, eb, e;
        logic [47:0] p;
        logic [24:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return QNAN;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return QNAN;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = ea + eb - 127;
        if (p[47]) begin
            e++;
            m  = {1'b0, p[47:24]};
            gb = p[23];
            st = |p[22:0];
        end else begin
            m  = {1'b0, p[46:23]};
            gb = p[22];
            st = |p[21:0];
        end
        if (gb && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic int model_grant(input logic [N-1:0] elig, input int ptr);
        for (int k = 0; k < N; k++)
            if (elig[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk($sformatf("%s_req_ready", name), 32'(req_ready), 0);
        chk($sformatf("%s_rsp_valid", name), 32'(rsp_valid), 0);
        chk($sformatf("%s_rsp_err", name), 32'(rsp_err), 0);
        chk($sformatf("%s_mul_ready", name), 32'(mul_ready), 0);
        chk($sformatf("%s_mul_op1", name), mul_op1, 0);
        chk($sformatf("%s_mul_op2", name), mul_op2, 0);
        chk($sformatf("%s_busy", name), 32'(busy), 0);
        chk($sformatf("%s_err_timeout", name), 32'(err_timeout), 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_rsp_res%0d", name, i), rsp_res[32*i +: 32], 0);
    endtask

    // Behavioural core: on a start pulse, answers after a random latency
    initial begin : core
        int          cnt;
        bit          pend;
        logic [31:0] a, b;
        core_done = 1'b0;
        mul_res   = '0;
        pend      = 0;
        cnt       = 0;
        a         = '0;
        b         = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_done = 1'b1;
                        mul_res   = fpmul(a, b);
                        pend      = 0;
                    end
                end
                if (mul_ready) begin
                    pulses++;
                    if (!hang) begin
                        pend = 1;
                        a    = mul_op1;
                        b    = mul_op2;
                        cnt  = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
                    end
                end
            end
        end
    end

    // Response monitor: scores each newly posted result and the handshake rules
    initial begin : monitor
        logic [N-1:0] pv, pr;
        logic [31:0]  pres [N];
        sb_t          e;
        pv = '0;
        pr = '0;
        for (int i = 0; i < N; i++) pres[i] = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                pv = '0;
                pr = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (rsp_valid[i] && !pv[i]) begin
                        chk("rsp_expected", 32'(sb_q.size() > 0), 1);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            chk("rsp_idx", i, e.idx);
                            chk("rsp_res", rsp_res[32*i +: 32], e.res);
                            chk("rsp_err", 32'(rsp_err[i]), 32'(e.err));
                        end
                    end else if (pv[i] && pr[i]) begin
                        chk("rsp_drop_after_consume", 32'(rsp_valid[i]), 0);
                    end else if (pv[i]) begin
                        chk("rsp_hold_valid", 32'(rsp_valid[i]), 1);
                        chk("rsp_hold_res", rsp_res[32*i +: 32], pres[i]);
                    end
                    pres[i] = rsp_res[32*i +: 32];
                end
                pv = rsp_valid;
                pr = rsp_ready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1);
    end

    task automatic on_grant(output int g);
        int eg;
        eg = model_grant(req_valid & ~rsp_valid, model_ptr);
        g  = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        chk("grant_onehot", 32'(req_ready), (eg < 0) ? 32'h0 : (32'h1 << eg));
        if (rsp_valid[1] && req_valid[1] && g != 1) skip_cnt++;
        sb_q.push_back('{idx: g, res: hang ? QNAN : exp_res[g], err: hang});
        model_ptr = (g + 1) % N;
        grants++;
        gcnt[g]++;
        gorder.push_back(g);
        iss_op1 = req_op1[32*g +: 32];
        iss_op2 = req_op2[32*g +: 32];
    endtask

    task automatic load_op(input int i);
        logic [31:0] a, b;
        if (dir_use[i]) begin
            a = dir_op1[i];
            b = dir_op2[i];
            exp_res[i] = dir_exp[i];
            dir_use[i] = 1'b0;
        end else begin
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            exp_res[i] = fpmul(a, b);
        end
        req_op1[32*i +: 32] = a;
        req_op2[32*i +: 32] = b;
    endtask

    task automatic drive_cycles(input string name, input int budget);
        logic [N-1:0] granted;
        bit           done;
        int           c, g;
        granted = '0;
        done    = 0;
        c       = 0;
        gorder.delete();
        skip_cnt = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
            for (int i = 0; i < N; i++) begin
                if (granted[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ops_left[i] > 0 && (gap_mode == 0 || $urandom_range(0, 2) == 0)) begin
                    load_op(i);
                    ops_left[i]--;
                    req_valid[i] = 1'b1;
                end
                case (rdy_mode)
                    0:       rsp_ready[i] = 1'($urandom_range(0, 1));
                    1:       rsp_ready[i] = 1'b1;
                    default: rsp_ready[i] = (i != 1) || (c >= 80);
                endcase
            end
            granted = '0;
            #2;
            if (issue_pend) begin
                chk("issue_busy", 32'(busy), 1);
                chk("issue_mul_ready", 32'(mul_ready), 1);
                chk("issue_op1", mul_op1, iss_op1);
                chk("issue_op2", mul_op2, iss_op2);
                issue_pend = 0;
            end
            if (|req_ready) begin
                on_grant(g);
                granted[g] = 1'b1;
                issue_pend = 1;
            end
            done = (req_valid == '0) && (sb_q.size() == 0) && !busy;
            for (int i = 0; i < N; i++) if (ops_left[i] > 0) done = 0;
        end
        chk({name, "_complete"}, 32'(done), 1);
        chk({name, "_mul_ready_pulses"}, pulses, grants);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        sb_q.delete();
        model_ptr = 0;
        issue_pend = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_dir(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        dir_use[i] = 1'b1;
        dir_op1[i] = a;
        dir_op2[i] = b;
        dir_exp[i] = r;
    endtask

    initial begin
        int g;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid = '0;
        req_op1 = '0;
        req_op2 = '0;
        rsp_ready = '0;
        stray_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            ops_left[i] = 0;
            dir_use[i]  = 1'b0;
            exp_res[i]  = '0;
            gcnt[i]     = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester 2: 1.0 * 2.0
        set_dir(2, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
        ops_left[2] = 1;
        rdy_mode = 1;
        drive_cycles("t1", 200);
        chk("t1_grants_req2", gcnt[2], 1);

        // Full load: strict rotation from ptr 0
        do_reset();
        set_dir(0, 32'hC040_0000, 32'h4080_0000, 32'hC140_0000);
        for (int i = 0; i < N; i++) ops_left[i] = 5;
        drive_cycles("t2", 1000);
        for (int k = 0; k < 5; k++)
            if (gorder.size() > k) chk("t2_order", gorder[k], exp_order[k]);

        // Requester 1 withholds rsp_ready: it is skipped until it consumes
        rdy_mode = 2;
        for (int i = 0; i < N; i++) ops_left[i] = 4;
        drive_cycles("t3", 1000);
        chk("t3_req1_skipped", 32'(skip_cnt > 0), 1);
        chk("t3_req1_grants", gcnt[1], 4);

        // Randomized traffic with gaps and random consumption
        rdy_mode = 0;
        gap_mode = 1;
        for (int i = 0; i < N; i++) ops_left[i] = 6;
        drive_cycles("rand", 3000);
        gap_mode = 0;
        rdy_mode = 1;

        // Special operands
        set_dir(0, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000);
        set_dir(1, 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
        ops_left[0] = 1;
        ops_left[1] = 1;
        drive_cycles("t5", 200);

        // Core never answers: watchdog after 16 WAIT cycles, then a stray done
        hang = 1;
        rsp_ready = '0;
        chk("t4_err_timeout_before", 32'(err_timeout), 0);
        @(negedge clk);
        req_op1[31:0] = 32'h3F80_0000;
        req_op2[31:0] = 32'h4000_0000;
        exp_res[0] = 32'h4000_0000;
        req_valid = 4'b0001;
        #2;
        chk("t4_grant", 32'(req_ready), 1);
        if (|req_ready) on_grant(g);
        @(negedge clk);
        req_valid = '0;
        #2;
        chk("t4_issue", 32'(mul_ready), 1);
        repeat (16) @(negedge clk);
        #2;
        chk("t4_no_rsp_at_wait15", 32'(rsp_valid[0]), 0);
        chk("t4_no_timeout_at_wait15", 32'(err_timeout), 0);
        chk("t4_busy_at_wait15", 32'(busy), 1);
        @(negedge clk);
        #2;
        chk("t4_rsp_valid", 32'(rsp_valid[0]), 1);
        chk("t4_rsp_err", 32'(rsp_err[0]), 1);
        chk("t4_err_timeout", 32'(err_timeout), 1);
        chk("t4_idle", 32'(busy), 0);
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        #2;
        chk("t4_stray_busy", 32'(busy), 0);
        chk("t4_stray_rsp_valid", 32'(rsp_valid), 1);
        chk("t4_stray_rsp_res", rsp_res[31:0], QNAN);
        chk("t4_stray_err_timeout", 32'(err_timeout), 1);
        rsp_ready = '1;
        repeat (2) @(negedge clk);
        #2;
        chk("t4_consumed", 32'(rsp_valid), 0);
        hang = 0;

        // Reset during WAIT, then a clean operation
        fixed_lat = 12;
        @(negedge clk);
        req_op1[127:96] = 32'h4040_0000;
        req_op2[127:96] = 32'h4040_0000;
        exp_res[3] = 32'h4110_0000;
        req_valid = 4'b1000;
        #2;
        chk("t6_grant", 32'(req_ready), 8);
        if (|req_ready) on_grant(g);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2;
        chk("t6_in_wait_busy", 32'(busy), 1);
        chk("t6_in_wait_mul_ready", 32'(mul_ready), 0);
        chk("t6_in_wait_op1", mul_op1, 32'h4040_0000);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        model_ptr = 0;
        #1;
        chk_zero("t6_async");
        @(negedge clk);
        #2;
        chk_zero("t6_next");
        fixed_lat = 0;
        @(negedge clk);
        rst = 1'b0;
        set_dir(3, 32'h40A0_0000, 32'h4040_0000, 32'h4170_0000);
        ops_left[3] = 1;
        drive_cycles("t6_after", 200);
        chk("t6_after_grants", gcnt[3], 1);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
